// File: rtl/tetris_input_pkg.sv
// ----------------------------------------------------------------------------
// tetris_input_pkg
// Shared definitions for the keyboard input path and the main game logic:
//   - user_event_t : 3-bit game event code carried through the event queue
//   - ps2_state_t  : set-2 scan-code parser states
//   - SC_*         : PS/2 set-2 scan-code bytes used by the decoder
//   - map_scan_code: make-code to game-event lookup
//   - is_dir_event : true for the auto-repeatable movement events
// ----------------------------------------------------------------------------
package tetris_input_pkg;

   typedef enum logic [2:0] {
      EV_LEFT     = 3'd0,
      EV_RIGHT    = 3'd1,
      EV_DOWN     = 3'd2,
      EV_ROTATE   = 3'd3,
      EV_DROP     = 3'd4,
      EV_NEW_GAME = 3'd5
   } user_event_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EXT     = 2'd1,
      BRK     = 2'd2,
      EXT_BRK = 2'd3
   } ps2_state_t;

   localparam logic [7:0] SC_EXT      = 8'hE0;
   localparam logic [7:0] SC_BRK      = 8'hF0;
   localparam logic [7:0] SC_LEFT     = 8'h6B;
   localparam logic [7:0] SC_RIGHT    = 8'h74;
   localparam logic [7:0] SC_DOWN     = 8'h72;
   localparam logic [7:0] SC_ROTATE   = 8'h75;
   localparam logic [7:0] SC_DROP     = 8'h29;
   localparam logic [7:0] SC_NEW_GAME = 8'h5A;

   typedef struct packed {
      logic        valid;
      user_event_t ev;
   } key_map_t;

   // Arrow keys only exist as extended (E0-prefixed) codes; DROP and NEW_GAME
   // only as plain codes, so the same byte means different things per prefix.
   function automatic key_map_t map_scan_code(input logic i_ext, input logic [7:0] i_code);
      key_map_t r_map;
      r_map.valid = 1'b0;
      r_map.ev    = EV_LEFT;
      if (i_ext) begin
         case (i_code)
            SC_LEFT:   begin r_map.valid = 1'b1; r_map.ev = EV_LEFT;   end
            SC_RIGHT:  begin r_map.valid = 1'b1; r_map.ev = EV_RIGHT;  end
            SC_DOWN:   begin r_map.valid = 1'b1; r_map.ev = EV_DOWN;   end
            SC_ROTATE: begin r_map.valid = 1'b1; r_map.ev = EV_ROTATE; end
            default:   begin r_map.valid = 1'b0; r_map.ev = EV_LEFT;   end
         endcase
      end else begin
         case (i_code)
            SC_DROP:     begin r_map.valid = 1'b1; r_map.ev = EV_DROP;     end
            SC_NEW_GAME: begin r_map.valid = 1'b1; r_map.ev = EV_NEW_GAME; end
            default:     begin r_map.valid = 1'b0; r_map.ev = EV_LEFT;     end
         endcase
      end
      return r_map;
   endfunction

   function automatic logic is_dir_event(input user_event_t i_ev);
      return (i_ev == EV_LEFT) || (i_ev == EV_RIGHT) || (i_ev == EV_DOWN);
   endfunction

endpackage

// File: rtl/user_event_fifo.sv
// ----------------------------------------------------------------------------
// user_event_fifo
// Show-ahead event queue: o_data always shows the head entry (0 when empty).
// A pop on an empty queue is ignored; a push into a full queue is only taken
// when a pop happens in the same cycle, otherwise the entry is discarded
// (the caller detects that through o_full / o_empty).
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_push, i_data : write request and event to store
//   i_pop        : remove head entry
//   o_data       : head entry
//   o_full, o_empty : occupancy flags
// ----------------------------------------------------------------------------
module user_event_fifo
   import tetris_input_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_push,
   input  user_event_t i_data,
   input  logic        i_pop,
   output user_event_t o_data,
   output logic        o_full,
   output logic        o_empty
);

   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   user_event_t       r_mem [DEPTH];
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W:0]   r_count;

   logic w_pop;
   logic w_push;

   assign o_full  = (r_count == (ADDR_W+1)'(DEPTH));
   assign o_empty = (r_count == {(ADDR_W+1){1'b0}});
   assign o_data  = o_empty ? user_event_t'(3'd0) : r_mem[r_rd_ptr];

   // A pop frees the head slot at this edge, so a push may reuse it while full.
   assign w_pop  = i_pop & ~o_empty;
   assign w_push = i_push & (~o_full | w_pop);

   // Pointer and occupancy tracking.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rd_ptr <= {ADDR_W{1'b0}};
         r_wr_ptr <= {ADDR_W{1'b0}};
         r_count  <= {(ADDR_W+1){1'b0}};
      end else begin
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
            2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage; contents are only visible through o_data when non-empty.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// ----------------------------------------------------------------------------
// ps2_key_decoder
// Turns PS/2 set-2 scan-code bytes into game events and queues them for the
// game logic. Optional auto-repeat of held movement keys is enabled by
// defining the macro USER_INPUT_AUTOREPEAT_EN.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   ps2_key_data_i        : received scan-code byte
//   ps2_key_data_en_i     : one-cycle strobe qualifying ps2_key_data_i
//   user_event_rd_req_i   : consumer pop request
//   user_event_o          : head-of-queue event (0 when empty)
//   user_event_ready_o    : queue non-empty
//   event_overflow_o      : sticky, an event was dropped on a full queue
// ----------------------------------------------------------------------------
module ps2_key_decoder
   import tetris_input_pkg::*;
#(
   parameter int FIFO_DEPTH          = 4,
   parameter int REPEAT_DELAY_TICKS  = 27_000_000,
   parameter int REPEAT_PERIOD_TICKS = 8_100_000
)(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] ps2_key_data_i,
   input  logic       ps2_key_data_en_i,
   input  logic       user_event_rd_req_i,
   output logic [2:0] user_event_o,
   output logic       user_event_ready_o,
   output logic       event_overflow_o
);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two and at least 2");
   end
   if (REPEAT_DELAY_TICKS < 1 || REPEAT_PERIOD_TICKS < 1) begin : g_bad_repeat
      $error("repeat tick counts must be at least 1");
   end

   ps2_state_t  r_state;
   ps2_state_t  w_next_state;
   logic        w_done;
   logic        w_ext;
   logic        w_break;
   key_map_t    w_map;
   logic        w_make_done;
   logic        w_push;
   user_event_t w_push_ev;
   logic        w_pop;
   logic        w_full;
   logic        w_empty;
   user_event_t w_head;
   logic        r_overflow;

   // Classify the strobed byte against the current parser state.
   always_comb begin
      w_next_state = r_state;
      w_done       = 1'b0;
      w_ext        = 1'b0;
      w_break      = 1'b0;
      if (ps2_key_data_en_i) begin
         case (r_state)
            IDLE: begin
               if (ps2_key_data_i == SC_EXT) begin
                  w_next_state = EXT;
               end else if (ps2_key_data_i == SC_BRK) begin
                  w_next_state = BRK;
               end else begin
                  w_next_state = IDLE;
                  w_done       = 1'b1;
               end
            end
            EXT: begin
               if (ps2_key_data_i == SC_BRK) begin
                  w_next_state = EXT_BRK;
               end else begin
                  w_next_state = IDLE;
                  w_done       = 1'b1;
                  w_ext        = 1'b1;
               end
            end
            BRK: begin
               w_next_state = IDLE;
               w_done       = 1'b1;
               w_break      = 1'b1;
            end
            EXT_BRK: begin
               w_next_state = IDLE;
               w_done       = 1'b1;
               w_ext        = 1'b1;
               w_break      = 1'b1;
            end
            default: begin
               w_next_state = IDLE;
            end
         endcase
      end else begin
         w_next_state = r_state;
      end
   end

   assign w_map       = map_scan_code(w_ext, ps2_key_data_i);
   assign w_make_done = w_done & ~w_break & w_map.valid;

   // Parser state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

`ifdef USER_INPUT_AUTOREPEAT_EN
   localparam int CNT_MAX = (REPEAT_DELAY_TICKS > REPEAT_PERIOD_TICKS) ?
                            REPEAT_DELAY_TICKS : REPEAT_PERIOD_TICKS;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   // The counter fires on reaching zero, so load one less than the tick count.
   localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY_TICKS - 1);
   localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD_TICKS - 1);

   logic             r_held_valid;
   user_event_t      r_held_key;
   logic [CNT_W-1:0] r_rpt_cnt;
   logic             w_dec_push;
   logic             w_new_dir;
   logic             w_held_break;
   logic             w_cnt_zero;
   logic             w_rpt_fire;

   assign w_cnt_zero = (r_rpt_cnt == {CNT_W{1'b0}});

   // Held-key bookkeeping; typematic makes of the held key are swallowed
   // because the repeat counter already produces those events.
   always_comb begin
      w_dec_push   = 1'b0;
      w_new_dir    = 1'b0;
      w_held_break = 1'b0;
      w_rpt_fire   = 1'b0;
      w_push       = 1'b0;
      w_push_ev    = w_map.ev;
      if (w_make_done && is_dir_event(w_map.ev) && r_held_valid && (w_map.ev == r_held_key)) begin
         w_dec_push = 1'b0;
      end else begin
         w_dec_push = w_make_done;
      end
      w_new_dir    = w_dec_push & is_dir_event(w_map.ev);
      w_held_break = w_done & w_break & w_map.valid & r_held_valid & (w_map.ev == r_held_key);
      w_rpt_fire   = r_held_valid & w_cnt_zero & ~w_held_break;
      // A decoded event wins the single push slot over a repeat.
      if (w_dec_push) begin
         w_push    = 1'b1;
         w_push_ev = w_map.ev;
      end else begin
         w_push    = w_rpt_fire;
         w_push_ev = r_held_key;
      end
   end

   // Held key and repeat countdown.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_held_valid <= 1'b0;
         r_held_key   <= EV_LEFT;
         r_rpt_cnt    <= {CNT_W{1'b0}};
      end else if (w_new_dir) begin
         r_held_valid <= 1'b1;
         r_held_key   <= w_map.ev;
         r_rpt_cnt    <= DELAY_LOAD;
      end else if (w_held_break) begin
         r_held_valid <= 1'b0;
         r_rpt_cnt    <= {CNT_W{1'b0}};
      end else if (r_held_valid && w_cnt_zero) begin
         // Reload whether the repeat was pushed or lost to a decoded event.
         r_rpt_cnt <= PERIOD_LOAD;
      end else if (r_held_valid) begin
         r_rpt_cnt <= r_rpt_cnt - CNT_W'(1);
      end else begin
         r_rpt_cnt <= r_rpt_cnt;
      end
   end
`else
   assign w_push    = w_make_done;
   assign w_push_ev = w_map.ev;
`endif

   assign w_pop = user_event_rd_req_i & ~w_empty;

   user_event_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (clk_i),
      .i_rst   (rst_i),
      .i_push  (w_push),
      .i_data  (w_push_ev),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Sticky drop flag; a same-cycle pop makes room so nothing is lost then.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_overflow <= 1'b0;
      end else if (w_push && w_full && !w_pop) begin
         r_overflow <= 1'b1;
      end else begin
         r_overflow <= r_overflow;
      end
   end

   assign user_event_o       = w_head;
   assign user_event_ready_o = ~w_empty;
   assign event_overflow_o   = r_overflow;

endmodule
